rtc_field_sequencer: RTL

- Parametrised command sequencer between the user-side time/date configuration logic and the RTC bus engine. Replaces the fixed per-field configuration FSM.
- Accepts one command at a time over a valid/ready handshake: init, write field, read field, or set 12/24-hour format.
- Drives one-hot field enables plus a data bus to the bus engine, waits for completion with a timeout, and returns a single-cycle response.
- Field count, data width, per-field bit masks and timeout are all parameters.

---
 rtl/rtc_field_sequencer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/rtc_field_sequencer.sv
// Command sequencer between the time/date configuration logic and the RTC bus engine.
// One command in flight; drives one-hot field strobes, waits for bus_done with a timeout, pulses a response.
module rtc_field_sequencer #(
  parameter int                           DATA_W      = 8,
  parameter int                           NUM_FIELDS  = 6,
  parameter int                           FIELD_W     = 3,
  parameter logic [NUM_FIELDS*DATA_W-1:0] FIELD_MASKS = {8'h7F, 8'h0F, 8'h1F, 8'h1F, 8'h3F, 8'h3F},
  parameter int                           HOUR_IDX    = 2,
  parameter int                           TIMEOUT     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [FIELD_W-1:0]    cmd_field,
  input  logic [DATA_W-1:0]     cmd_data,
  input  logic                  cmd_fmt12,
  output logic                  bus_init,
  output logic                  bus_wr,
  output logic                  bus_rd,
  output logic [NUM_FIELDS-1:0] bus_field_en,
  output logic [DATA_W-1:0]     bus_data,
  input  logic                  bus_done,
  input  logic [DATA_W-1:0]     bus_rdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  fmt12_q,
  output logic                  busy
);
  // state  | meaning
  // IDLE   | cmd_ready high, waiting for a command
  // ACTIVE | strobes driven, timeout counter running
  // GAP    | one cycle strobes low between the two init phases
  // RESP   | rsp_valid pulse
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP, S_RESP} state_t;

  localparam logic [1:0]       OP_INIT = 2'b00;
  localparam logic [1:0]       OP_WR   = 2'b01;
  localparam logic [1:0]       OP_RD   = 2'b10;
  localparam logic [1:0]       OP_FMT  = 2'b11;
  localparam int               TW      = $clog2(TIMEOUT);
  localparam logic [FIELD_W:0] NF      = (FIELD_W+1)'(NUM_FIELDS);
  localparam logic [FIELD_W-1:0] HOUR  = FIELD_W'(HOUR_IDX);

  function automatic logic [DATA_W-1:0] f_mask(input logic [FIELD_W-1:0] f);
    f_mask = '0;
    for (int i = 0; i < NUM_FIELDS; i++)
      if (f == FIELD_W'(i)) f_mask = FIELD_MASKS[i*DATA_W +: DATA_W];
  endfunction

  function automatic logic [NUM_FIELDS-1:0] f_onehot(input logic [FIELD_W-1:0] f);
    f_onehot = '0;
    for (int i = 0; i < NUM_FIELDS; i++)
      if (f == FIELD_W'(i)) f_onehot[i] = 1'b1;
  endfunction

  state_t                r_state, w_nxt_state;
  logic                  r_phase, w_nx_phase;
  logic [TW-1:0]         r_tmr;
  logic [1:0]            r_op;
  logic [FIELD_W-1:0]    r_field;
  logic [DATA_W-1:0]     r_data;
  logic                  r_fmt;
  logic                  r_cmd_ready, r_init, r_wr, r_rd, r_rsp_valid, r_rsp_err, r_fmt12, r_busy;
  logic [NUM_FIELDS-1:0] r_field_en;
  logic [DATA_W-1:0]     r_bus_data, r_rsp_data;

  logic                  w_nx_init, w_nx_wr, w_nx_rd, w_nx_err, w_nx_fmt12;
  logic [NUM_FIELDS-1:0] w_nx_en;
  logic [DATA_W-1:0]     w_nx_data, w_nx_rsp_data;

  // In IDLE the live command inputs stand in for the not-yet-captured copy.
  logic               w_idle, w_accept, w_done, w_tc, w_reject;
  logic [1:0]         w_op;
  logic [FIELD_W-1:0] w_field;
  logic [DATA_W-1:0]  w_md;
  logic               w_fmt;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle && cmd_valid && r_cmd_ready;
  assign w_op     = w_idle ? cmd_op    : r_op;
  assign w_field  = w_idle ? cmd_field : r_field;
  assign w_fmt    = w_idle ? cmd_fmt12 : r_fmt;
  assign w_md     = (w_idle ? cmd_data : r_data) & f_mask(w_field);
  assign w_done   = (r_state == S_ACTIVE) && bus_done;
  assign w_tc     = (r_tmr == '0);
  assign w_reject = (((w_op == OP_WR) || (w_op == OP_RD)) && ({1'b0, w_field} >= NF)) ||
                    ((w_op == OP_WR) && (w_field == HOUR) && r_fmt12 &&
                     ((w_md == '0) || (w_md > DATA_W'(12))));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_nxt_state = w_reject ? S_RESP : S_ACTIVE;
      S_ACTIVE: begin
        if (bus_done)  w_nxt_state = ((r_op == OP_INIT) && !r_phase) ? S_GAP : S_RESP;
        else if (w_tc) w_nxt_state = S_RESP;
      end
      S_GAP:    w_nxt_state = S_ACTIVE;
      default:  w_nxt_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_nx_init     = 1'b0;
    w_nx_wr       = 1'b0;
    w_nx_rd       = 1'b0;
    w_nx_en       = '0;
    w_nx_data     = '0;
    w_nx_phase    = w_idle ? 1'b0 : ((w_done && (w_nxt_state == S_GAP)) ? 1'b1 : r_phase);
    w_nx_err      = (w_nxt_state == S_RESP) && !w_done;
    w_nx_fmt12    = (w_done && (r_op == OP_FMT)) ? r_fmt : r_fmt12;
    w_nx_rsp_data = r_rsp_data;
    if (w_done && (w_nxt_state == S_RESP))
      w_nx_rsp_data = (r_op == OP_RD) ? (bus_rdata & f_mask(r_field)) : '0;
    else if (w_idle && (w_nxt_state == S_RESP))
      w_nx_rsp_data = '0;
    if (w_nxt_state == S_ACTIVE) begin
      case (w_op)
        OP_INIT: begin
          w_nx_init = 1'b1;
          w_nx_data = w_nx_phase ? '0 : DATA_W'(1);
        end
        OP_WR: begin
          w_nx_wr   = 1'b1;
          w_nx_en   = f_onehot(w_field);
          w_nx_data = w_md;
        end
        OP_RD: begin
          w_nx_rd = 1'b1;
          w_nx_en = f_onehot(w_field);
        end
        default: begin
          w_nx_wr      = 1'b1;
          w_nx_en      = f_onehot(HOUR);
          w_nx_data[4] = w_fmt;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase     <= 1'b0;
      r_tmr       <= '0;
      r_op        <= OP_INIT;
      r_field     <= '0;
      r_data      <= '0;
      r_fmt       <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_init      <= 1'b0;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_field_en  <= '0;
      r_bus_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
      r_fmt12     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op    <= cmd_op;
        r_field <= cmd_field;
        r_data  <= cmd_data;
        r_fmt   <= cmd_fmt12;
      end
      if ((w_nxt_state == S_ACTIVE) && (r_state != S_ACTIVE)) r_tmr <= TW'(TIMEOUT - 1);
      else if ((r_state == S_ACTIVE) && !w_tc)                r_tmr <= r_tmr - TW'(1);
      r_phase     <= w_nx_phase;
      r_cmd_ready <= (w_nxt_state == S_IDLE);
      r_busy      <= (w_nxt_state != S_IDLE);
      r_init      <= w_nx_init;
      r_wr        <= w_nx_wr;
      r_rd        <= w_nx_rd;
      r_field_en  <= w_nx_en;
      r_bus_data  <= w_nx_data;
      r_rsp_valid <= (w_nxt_state == S_RESP);
      r_rsp_err   <= w_nx_err;
      r_rsp_data  <= w_nx_rsp_data;
      r_fmt12     <= w_nx_fmt12;
    end
  end

  assign cmd_ready    = r_cmd_ready;
  assign busy         = r_busy;
  assign bus_init     = r_init;
  assign bus_wr       = r_wr;
  assign bus_rd       = r_rd;
  assign bus_field_en = r_field_en;
  assign bus_data     = r_bus_data;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_err      = r_rsp_err;
  assign rsp_data     = r_rsp_data;
  assign fmt12_q      = r_fmt12;

endmodule
